// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic tile sequencer.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_e;

  // Skew/drain latency: one read-latency cycle, ROWS+COLS-2 skew cycles, one MAC cycle.
  function automatic int drain_cycles(input int rows, input int cols);
    return rows + cols;
  endfunction

  // Width needed to hold any value 0..max_count.
  function automatic int count_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/systolic_tile_sequencer.sv
// Sequences one tile product: clears the PE accumulators, streams k_len operand
// rows/columns into the input controller, waits out the array drain, then pulses done.
module systolic_tile_sequencer
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int K_MAX      = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [$clog2(K_MAX+1)-1:0] k_len,
  input  logic [ADDR_WIDTH-1:0]      a_base,
  input  logic [ADDR_WIDTH-1:0]      b_base,
  output logic                       a_rd_en,
  output logic                       b_rd_en,
  output logic [ADDR_WIDTH-1:0]      a_rd_addr,
  output logic [ADDR_WIDTH-1:0]      b_rd_addr,
  input  logic [DATA_WIDTH*ROWS-1:0] a_rd_data,
  input  logic [DATA_WIDTH*COLS-1:0] b_rd_data,
  output logic                       ctl_enable,
  output logic [DATA_WIDTH*ROWS-1:0] ctl_A,
  output logic [DATA_WIDTH*COLS-1:0] ctl_B,
  output logic                       pe_clear,
  output logic                       busy,
  output logic                       done
);

  localparam int KW           = count_width(K_MAX);
  localparam int DRAIN_CYCLES = drain_cycles(ROWS, COLS);
  localparam int CW           = count_width((K_MAX > DRAIN_CYCLES) ? K_MAX : DRAIN_CYCLES);

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
  logic [ADDR_WIDTH-1:0] b_addr_q, b_addr_d;
  logic                  en_q, en_d;

  logic                  feed;
  logic                  feed_last;
  logic                  drain_last;

  assign feed_last  = (cnt_q == (CW'(k_q) - CW'(1)));
  assign drain_last = (cnt_q == CW'(DRAIN_CYCLES - 1));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    feed     = 1'b0;
    pe_clear = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          k_d      = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
          a_addr_d = a_base;
          b_addr_d = b_base;
          cnt_d    = '0;
          state_d  = (k_len == '0) ? DONE : CLEAR;
        end
      end
      CLEAR: begin
        pe_clear = 1'b1;
        state_d  = FEED;
      end
      FEED: begin
        feed     = 1'b1;
        a_addr_d = a_addr_q + ADDR_WIDTH'(1);
        b_addr_d = b_addr_q + ADDR_WIDTH'(1);
        if (feed_last) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (drain_last) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The buffer returns data one cycle after the read strobe, so the enable is delayed to match.
  assign en_d = feed;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      cnt_q    <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      en_q     <= en_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign a_rd_en    = feed;
  assign b_rd_en    = feed;
  assign a_rd_addr  = feed ? a_addr_q : '0;
  assign b_rd_addr  = feed ? b_addr_q : '0;
  assign ctl_enable = en_q;
  assign ctl_A      = en_q ? a_rd_data : '0;
  assign ctl_B      = en_q ? b_rd_data : '0;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Self-checking bench for systolic_tile_sequencer: table-driven tiles plus
// hand-written sequences for held start and reset during FEED.
module tb_systolic_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  k_len;
  logic [7:0]  a_base, b_base;
  logic        a_rd_en, b_rd_en;
  logic [7:0]  a_rd_addr, b_rd_addr;
  logic [31:0] a_rd_data, b_rd_data;
  logic        ctl_enable;
  logic [31:0] ctl_A, ctl_B;
  logic        pe_clear, busy, done;

  int checks   = 0;
  int failures = 0;

  systolic_tile_sequencer #(
    .DATA_WIDTH(8), .ROWS(4), .COLS(4), .K_MAX(16), .ADDR_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .a_base(a_base), .b_base(b_base),
    .a_rd_en(a_rd_en), .b_rd_en(b_rd_en),
    .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr),
    .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
    .ctl_enable(ctl_enable), .ctl_A(ctl_A), .ctl_B(ctl_B),
    .pe_clear(pe_clear), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat_a(input logic [7:0] ad);
    return {ad + 8'd3, ad + 8'd2, ad + 8'd1, ad};
  endfunction

  function automatic logic [31:0] pat_b(input logic [7:0] ad);
    return {ad, ad ^ 8'hFF, ad + 8'h40, ad + 8'h80};
  endfunction

  // Operand buffers: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    a_rd_data <= a_rd_en ? pat_a(a_rd_addr) : 32'hDEAD_BEEF;
    b_rd_data <= b_rd_en ? pat_b(b_rd_addr) : 32'hCAFE_F00D;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs_nonzero();
    return int'(busy | done | pe_clear | ctl_enable | a_rd_en | b_rd_en |
                (|a_rd_addr) | (|b_rd_addr) | (|ctl_A) | (|ctl_B));
  endfunction

  typedef struct {
    logic [4:0] k;
    logic [7:0] ab;
    logic [7:0] bb;
    int         exp_n;
    int         exp_done;
    string      tag;
  } vec_t;

  vec_t vecs[6];

  // Issues one tile and observes cycles 1..32 (sampled at negedge).
  task automatic run_tile(input vec_t v);
    int n_clear = 0, clear_cyc = 0, n_rd = 0, first_rd = 0;
    int n_en = 0, first_en = 0, n_done = 0, done_cyc = 0;
    int busy_n = 0, busy_last = 0, bad_addr = 0, bad_data = 0;
    logic [7:0] ea, eb;
    @(negedge clk);
    start = 1'b1; k_len = v.k; a_base = v.ab; b_base = v.bb;
    @(negedge clk);
    start = 1'b0; k_len = 5'd7; a_base = 8'h99; b_base = 8'h66;
    for (int c = 1; c <= 32; c++) begin
      if (pe_clear) begin n_clear++; clear_cyc = c; end
      if (a_rd_en != b_rd_en) bad_addr++;
      if (a_rd_en) begin
        n_rd++;
        if (first_rd == 0) first_rd = c;
        ea = v.ab + 8'(c - 2);
        eb = v.bb + 8'(c - 2);
        if (a_rd_addr != ea || b_rd_addr != eb) bad_addr++;
      end else if (a_rd_addr != 8'h00 || b_rd_addr != 8'h00) begin
        bad_addr++;
      end
      if (ctl_enable) begin
        n_en++;
        if (first_en == 0) first_en = c;
        ea = v.ab + 8'(c - 3);
        eb = v.bb + 8'(c - 3);
        if (ctl_A != pat_a(ea) || ctl_B != pat_b(eb)) bad_data++;
      end else if (ctl_A != 32'h0 || ctl_B != 32'h0) begin
        bad_data++;
      end
      if (done) begin n_done++; done_cyc = c; end
      if (busy) begin busy_n++; busy_last = c; end
      @(negedge clk);
    end
    check({v.tag, ".n_clear"},   n_clear,   (v.exp_n > 0) ? 1 : 0);
    check({v.tag, ".clear_cyc"}, clear_cyc, (v.exp_n > 0) ? 1 : 0);
    check({v.tag, ".n_rd"},      n_rd,      v.exp_n);
    check({v.tag, ".first_rd"},  first_rd,  (v.exp_n > 0) ? 2 : 0);
    check({v.tag, ".n_en"},      n_en,      v.exp_n);
    check({v.tag, ".first_en"},  first_en,  (v.exp_n > 0) ? 3 : 0);
    check({v.tag, ".n_done"},    n_done,    1);
    check({v.tag, ".done_cyc"},  done_cyc,  v.exp_done);
    check({v.tag, ".busy_n"},    busy_n,    v.exp_done);
    check({v.tag, ".busy_last"}, busy_last, v.exp_done);
    check({v.tag, ".bad_addr"},  bad_addr,  0);
    check({v.tag, ".bad_data"},  bad_data,  0);
  endtask

  initial begin
    vecs[0] = '{5'd4,  8'h10, 8'h20, 4,  14, "k4"};
    vecs[1] = '{5'd4,  8'hFE, 8'h01, 4,  14, "wrap"};
    vecs[2] = '{5'd0,  8'h33, 8'h44, 0,  1,  "k0"};
    vecs[3] = '{5'd31, 8'h00, 8'h80, 16, 26, "clamp"};
    vecs[4] = '{5'd1,  8'hF0, 8'h0F, 1,  11, "k1"};
    vecs[5] = '{5'd16, 8'hF8, 8'hFF, 16, 26, "kmax"};

    rst_n = 1'b0; start = 1'b0; k_len = '0; a_base = '0; b_base = '0;
    #3;
    check("reset_outputs", outs_nonzero(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", outs_nonzero(), 0);

    for (int i = 0; i < 6; i++) run_tile(vecs[i]);

    // Wrap sequence spelled out explicitly.
    begin
      logic [7:0] seq [4];
      logic [7:0] want [4];
      int n = 0;
      want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00; want[3] = 8'h01;
      @(negedge clk);
      start = 1'b1; k_len = 5'd4; a_base = 8'hFE; b_base = 8'h00;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
        if (a_rd_en && n < 4) begin seq[n] = a_rd_addr; n++; end
        @(negedge clk);
      end
      check("wrap.count", n, 4);
      for (int j = 0; j < 4; j++)
        check($sformatf("wrap.addr%0d", j), int'(seq[j]), int'(want[j]));
    end

    // Start held high: ignored while busy (incl. DONE), re-accepted after one IDLE cycle.
    begin
      int clr1 = 0, clr2 = 0, dn1 = 0, dn2 = 0, n_clear = 0, idle_n = 0;
      @(negedge clk);
      start = 1'b1; k_len = 5'd2; a_base = 8'h40; b_base = 8'h50;
      @(negedge clk);
      for (int c = 1; c <= 26; c++) begin
        if (pe_clear) begin
          n_clear++;
          if (clr1 == 0) clr1 = c; else clr2 = c;
        end
        if (done) begin
          if (dn1 == 0) dn1 = c; else dn2 = c;
        end
        if (!busy) idle_n++;
        if (c == 26) start = 1'b0;
        @(negedge clk);
      end
      check("held.n_clear", n_clear, 2);
      check("held.clear1", clr1, 1);
      check("held.clear2", clr2, 14);
      check("held.done1", dn1, 12);
      check("held.done2", dn2, 25);
      check("held.idle_cycles", idle_n, 2);
      repeat (4) @(negedge clk);
      check("held.idle_after", int'(busy), 0);
    end

    // Reset asserted mid-FEED (cycle 3) clears outputs asynchronously.
    begin
      @(negedge clk);
      start = 1'b1; k_len = 5'd4; a_base = 8'h10; b_base = 8'h20;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rstfeed.enable_before", int'(ctl_enable & a_rd_en), 1);
      rst_n = 1'b0;
      #1;
      check("rstfeed.outputs", outs_nonzero(), 0);
      @(negedge clk);
      check("rstfeed.held", outs_nonzero(), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rstfeed.idle", outs_nonzero(), 0);
      run_tile(vecs[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_tile_sequencer.md
# systolic_tile_sequencer

Sequences one matrix tile product through the systolic array. On a start pulse it clears the PE accumulators and streams k_len A rows and B columns out of the operand buffers into Systolic_input_controller, gating its enable. It then waits out the skew/drain latency and signals completion. It sits between the host command interface and the input-controller/PE-array datapath.

## Interface
Parameters:
- DATA_WIDTH, 8, operand element width
- ROWS, 4, array rows (A lanes)
- COLS, 4, array columns (B lanes)
- K_MAX, 16, maximum inner-product length per tile
- ADDR_WIDTH, 8, operand buffer address width

Ports (reset: asynchronous, active-low, on rst_n; single clock clk):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  tile request; accepted only in IDLE
- k_len  in  $clog2(K_MAX+1)  inner-product length; sampled when start is accepted
- a_base  in  ADDR_WIDTH  first A buffer address; sampled on accepted start
- b_base  in  ADDR_WIDTH  first B buffer address; sampled on accepted start
- a_rd_en / b_rd_en  out  1  buffer read strobes
- a_rd_addr / b_rd_addr  out  ADDR_WIDTH  buffer read addresses
- a_rd_data  in  DATA_WIDTH*ROWS  A buffer data, valid 1 cycle after a_rd_en
- b_rd_data  in  DATA_WIDTH*COLS  B buffer data, valid 1 cycle after b_rd_en
- ctl_enable  out  1  enable to Systolic_input_controller
- ctl_A  out  DATA_WIDTH*ROWS  A vector to input controller (= a_rd_data when ctl_enable, else 0)
- ctl_B  out  DATA_WIDTH*COLS  B vector to input controller (= b_rd_data when ctl_enable, else 0)
- pe_clear  out  1  one-cycle accumulator clear to PE array
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the tile result is complete

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: start=1 latches k_len (values above K_MAX clamp to K_MAX), a_base and b_base. Goes to CLEAR, or to DONE if k_len==0.
- CLEAR: 1 cycle; pe_clear=1; goes to FEED.
- FEED: exactly k_len cycles. a_rd_en=b_rd_en=1. Addresses are base+i for i=0..k_len-1, wrapping modulo 2^ADDR_WIDTH. Goes to DRAIN after the k_len-th cycle.
- ctl_enable is a_rd_en delayed one register stage, so it is high for exactly k_len consecutive cycles, aligned with the returning buffer data.
- DRAIN: ROWS+COLS cycles. This covers one read-latency cycle, ROWS+COLS-2 skew cycles and one PE MAC cycle. Goes to DONE.
- DONE: 1 cycle; done=1; goes to IDLE.
- start outside IDLE is ignored, including in the DONE cycle; there is no queueing.
- Reset at any time: returns to IDLE immediately; all outputs go low and the pipeline register is cleared.
- Reset values: busy=0, done=0, pe_clear=0, ctl_enable=0, a_rd_en=b_rd_en=0, addresses=0, ctl_A=ctl_B=0.

## Timing
- Cycle n is the first cycle after the edge that accepts start.
- CLEAR: cycle 1.
- FEED: cycles 2..k+1.
- ctl_enable: cycles 3..k+2.
- DRAIN: cycles k+2..k+1+ROWS+COLS.
- done: cycle k+2+ROWS+COLS.
- busy: cycles 1..k+2+ROWS+COLS.
- With k_len=0, busy and done are high in cycle 1 only; no pe_clear, read or enable is issued.
- A start asserted in the cycle after done (IDLE) is accepted, so back-to-back tiles have a gap of one IDLE cycle.
- The FEED/DRAIN boundary overlaps with the last ctl_enable cycle (k+2). This is intentional.

## Structure
- Shared package systolic_pkg:
  - state typedef: IDLE, CLEAR, FEED, DRAIN, DONE
  - localparam DRAIN_CYCLES = ROWS+COLS
  - the counter-width expression $clog2(K_MAX+1)
- Single module, no sub-module. It holds:
  - one step counter, reused for FEED and DRAIN
  - two address registers
  - the one-stage enable/data alignment register

## Test plan
- Reset then idle: all outputs 0; start with k_len=4, a_base=0x10, b_base=0x20 (ROWS=COLS=4). Required: pe_clear in cycle 1; addresses 0x10..0x13 / 0x20..0x23 in cycles 2-5; ctl_enable in cycles 3-6 carrying buffer words 1,2,3,4 → 10,20,30,40 …; done in cycle 14; busy in cycles 1-14.
- Wrap: a_base=0xFE, k_len=4. Required: a_rd_addr sequence FE, FF, 00, 01.
- k_len=0 gives busy=done=1 for one cycle with no reads. k_len=31 (above K_MAX=16) gives exactly 16 enable cycles.
- start held high continuously from cycle 0: it is ignored while busy, and the second tile starts on the cycle after done; pe_clear appears again in the new tile's cycle 1.
- rst_n low during FEED (cycle 3): all outputs are 0 asynchronously; after release the block is in IDLE and the next start behaves as in scenario 1.
